// File: rtl/temp_osc_pkg.sv
// Shared types and default timing for the ring-oscillator temperature measurement block.
`timescale 1ns/1ps
package temp_osc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    HOLD,
    DONE
  } state_t;

  localparam int CNT_W_DEF         = 10;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int WINDOW_CYCLES_DEF = 1;
  localparam int HOLD_CYCLES_DEF   = 2;
  localparam int TMR_W             = 8;

endpackage

// File: rtl/temp_osc_edge_counter.sv
// Saturating ana_clk edge counter with a 2-FF gate synchronizer; clr clears it asynchronously.
`timescale 1ns/1ps
module temp_osc_edge_counter #(
  parameter int CNT_W = 10
) (
  input  logic             ana_clk_i,
  input  logic             clr_i,
  input  logic             gate_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             gate_s1_q;
  logic             gate_s2_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (gate_s2_q && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // gate only opens while clr is low, so clearing the synchronizer with it is harmless
  always_ff @(posedge ana_clk_i or posedge clr_i) begin
    if (clr_i) begin
      gate_s1_q <= 1'b0;
      gate_s2_q <= 1'b0;
      count_q   <= '0;
    end else begin
      gate_s1_q <= gate_i;
      gate_s2_q <= gate_s1_q;
      count_q   <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/temp_osc_measure.sv
// Gates ana_clk edges over a window of lf_clk periods and publishes the count with a done pulse.
`timescale 1ns/1ps
module temp_osc_measure
  import temp_osc_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
  parameter int HOLD_CYCLES   = HOLD_CYCLES_DEF
) (
  input  logic             lf_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ana_clk,
  output logic             ana_en,
  output logic             done,
  output logic [CNT_W-1:0] cycles
);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               ana_en_q, ana_en_d;
  logic               clr_q, clr_d;
  logic               gate_q, gate_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;
  logic [CNT_W-1:0]   count;

  temp_osc_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .ana_clk_i (ana_clk),
    .clr_i     (clr_q),
    .gate_i    (gate_q),
    .count_o   (count)
  );

  // timer holds the remaining cycles of the current phase minus one
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          timer_d = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (timer_q == '0) begin
          state_d = COUNT;
          timer_d = TMR_W'(WINDOW_CYCLES - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      COUNT: begin
        if (timer_q == '0) begin
          state_d = HOLD;
          timer_d = TMR_W'(HOLD_CYCLES - 1);
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        if (start) begin
          state_d = SETTLE;
          timer_d = TMR_W'(SETTLE_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Controls are decoded from the next state so they are registered, glitch-free copies of it.
  // The counter is frozen through HOLD, so sampling it on the edge into DONE is safe.
  always_comb begin
    ana_en_d = state_d inside {SETTLE, COUNT, HOLD};
    clr_d    = state_d inside {IDLE, SETTLE};
    gate_d   = (state_d == COUNT);
    done_d   = (state_d == DONE);
    cycles_d = cycles_q;
    if (state_d == DONE) begin
      cycles_d = count;
    end
  end

  always_ff @(posedge lf_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      ana_en_q <= 1'b0;
      clr_q    <= 1'b1;
      gate_q   <= 1'b0;
      done_q   <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ana_en_q <= ana_en_d;
      clr_q    <= clr_d;
      gate_q   <= gate_d;
      done_q   <= done_d;
      cycles_q <= cycles_d;
    end
  end

  assign ana_en = ana_en_q;
  assign done   = done_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_temp_osc_measure.sv
// Directed bench for temp_osc_measure: timing of done pulses and count ranges at several ana_clk rates.
`timescale 1ns/1ps
module tb_temp_osc_measure;

  logic       lf_clk  = 1'b0;
  logic       rst_n   = 1'b0;
  logic       start   = 1'b0;
  logic       ana_clk = 1'b0;
  logic       ana_en;
  logic       done;
  logic [9:0] cycles;

  int  checks = 0;
  int  errors = 0;
  real ana_half = 50.0;
  bit  ana_run  = 1'b0;

  temp_osc_measure dut (
    .lf_clk  (lf_clk),
    .rst_n   (rst_n),
    .start   (start),
    .ana_clk (ana_clk),
    .ana_en  (ana_en),
    .done    (done),
    .cycles  (cycles)
  );

  always #15258.5 lf_clk = ~lf_clk;

  always begin
    if (ana_run) begin
      #(ana_half) ana_clk = ~ana_clk;
    end else begin
      ana_clk = 1'b0;
      #100;
    end
  end

  // Counts falling lf_clk edges until done is seen; ok=0 if the limit expires first.
  task automatic wait_done(input int limit, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    while ((n < limit) && !ok) begin
      @(negedge lf_clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #100;
    checks++;
    if (ana_en !== 1'b0) begin errors++; $display("FAIL reset_ana_en: got %b, want 0", ana_en); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
    checks++;
    if (cycles !== 10'd0) begin errors++; $display("FAIL reset_cycles: got %0d, want 0", cycles); end
    @(negedge lf_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_idle();
    ana_run  = 1'b1;
    ana_half = 50.0;
    repeat (20) begin
      @(negedge lf_clk);
      checks++;
      if ((ana_en !== 1'b0) || (done !== 1'b0) || (cycles !== 10'd0)) begin
        errors++;
        $display("FAIL idle: ana_en=%b done=%b cycles=%0d, want 0/0/0", ana_en, done, cycles);
      end
    end
  endtask

  task automatic test_nominal();
    int n;
    bit ok;
    start = 1'b1;
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 6) begin errors++; $display("FAIL nominal_first_latency: got %0d (seen=%b), want 6", n, ok); end
    checks++;
    if (ana_en !== 1'b0) begin errors++; $display("FAIL nominal_ana_en_in_done: got %b, want 0", ana_en); end
    checks++;
    if (cycles < 10'd303 || cycles > 10'd307) begin
      errors++; $display("FAIL nominal_cycles: got %0d, want 303..307", cycles);
    end
    @(negedge lf_clk);
    checks++;
    if ((ana_en !== 1'b1) || (done !== 1'b0)) begin
      errors++; $display("FAIL nominal_settle: ana_en=%b done=%b, want 1/0", ana_en, done);
    end
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 5) begin errors++; $display("FAIL nominal_period0: got %0d (seen=%b), want 5", n, ok); end
    for (int k = 0; k < 2; k++) begin
      wait_done(20, n, ok);
      checks++;
      if (!ok || n != 6) begin errors++; $display("FAIL nominal_period: got %0d (seen=%b), want 6", n, ok); end
      checks++;
      if (cycles < 10'd303 || cycles > 10'd307) begin
        errors++; $display("FAIL nominal_cycles_rep: got %0d, want 303..307", cycles);
      end
    end
  endtask

  task automatic test_freq_step();
    int n;
    bit ok;
    ana_half = 500.0;
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 6) begin errors++; $display("FAIL step_1mhz_period: got %0d (seen=%b), want 6", n, ok); end
    checks++;
    if (cycles < 10'd28 || cycles > 10'd33) begin
      errors++; $display("FAIL step_1mhz_cycles: got %0d, want 28..33", cycles);
    end
    ana_half = 25.0;
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 6) begin errors++; $display("FAIL step_20mhz_period: got %0d (seen=%b), want 6", n, ok); end
    checks++;
    if (cycles < 10'd608 || cycles > 10'd612) begin
      errors++; $display("FAIL step_20mhz_cycles: got %0d, want 608..612", cycles);
    end
  endtask

  task automatic test_saturation();
    int n;
    bit ok;
    ana_half = 10.0;
    for (int k = 0; k < 2; k++) begin
      wait_done(20, n, ok);
      checks++;
      if (!ok || n != 6) begin errors++; $display("FAIL sat_period: got %0d (seen=%b), want 6", n, ok); end
      checks++;
      if (cycles !== 10'd1023) begin errors++; $display("FAIL sat_cycles: got %0d, want 1023", cycles); end
    end
  endtask

  task automatic test_stop();
    int n;
    bit ok;
    ana_half = 50.0;
    repeat (3) @(negedge lf_clk);
    start = 1'b0;
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 3) begin errors++; $display("FAIL stop_last_done: got %0d (seen=%b), want 3", n, ok); end
    checks++;
    if (cycles < 10'd303 || cycles > 10'd307) begin
      errors++; $display("FAIL stop_cycles: got %0d, want 303..307", cycles);
    end
    repeat (12) begin
      @(negedge lf_clk);
      checks++;
      if ((ana_en !== 1'b0) || (done !== 1'b0)) begin
        errors++; $display("FAIL stop_idle: ana_en=%b done=%b, want 0/0", ana_en, done);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    logic [9:0] prev;
    prev  = cycles;
    start = 1'b1;
    @(negedge lf_clk);
    checks++;
    if ((ana_en !== 1'b1) || (cycles !== prev)) begin
      errors++; $display("FAIL restart_hold: ana_en=%b cycles=%0d, want 1/%0d", ana_en, cycles, prev);
    end
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 5) begin errors++; $display("FAIL restart_latency: got %0d (seen=%b), want 5", n, ok); end
    repeat (3) @(negedge lf_clk);
    #5;
    rst_n = 1'b0;
    #1;
    checks++;
    if ((ana_en !== 1'b0) || (done !== 1'b0) || (cycles !== 10'd0)) begin
      errors++; $display("FAIL midreset: ana_en=%b done=%b cycles=%0d, want 0/0/0", ana_en, done, cycles);
    end
    #9;
    rst_n = 1'b1;
    wait_done(20, n, ok);
    checks++;
    if (!ok || n != 6) begin errors++; $display("FAIL midreset_next_done: got %0d (seen=%b), want 6", n, ok); end
    checks++;
    if (cycles < 10'd303 || cycles > 10'd307) begin
      errors++; $display("FAIL midreset_cycles: got %0d, want 303..307", cycles);
    end
  endtask

  task automatic test_no_osc();
    int n;
    bit ok;
    ana_run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wait_done(20, n, ok);
      checks++;
      if (!ok || n != 6) begin errors++; $display("FAIL noosc_period: got %0d (seen=%b), want 6", n, ok); end
      checks++;
      if (cycles !== 10'd0) begin errors++; $display("FAIL noosc_cycles: got %0d, want 0", cycles); end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_nominal();
    test_freq_step();
    test_saturation();
    test_stop();
    test_reset_mid();
    test_no_osc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
